fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of decode (register-file read and immediate generation).
- Owns the PC, issues in-order word requests to instruction memory, and buffers returned instructions in a small FIFO.
- Presents {pc, insn, opcode} to decode over a valid/ready handshake.
- Handles control-flow redirects by flushing queued instructions and discarding stale in-flight responses.

---
 rtl/fetch_unit_pkg.sv | 23 ++
 rtl/fetch_fifo.sv | 64 ++++++
 rtl/fetch_unit.sv | 166 ++++++++++++++++
 tb/tb_fetch_unit.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage constants and types.
// Holds the reset PC, the sequential PC increment, the opcode field position
// (also used by decode) and the layout of one buffered instruction.
package fetch_unit_pkg;

   localparam int unsigned FETCH_AWIDTH = 32;
   localparam int unsigned FETCH_DWIDTH = 32;

   localparam logic [FETCH_AWIDTH-1:0] FETCH_BASEADDR = 32'h0100_0000;
   localparam logic [FETCH_AWIDTH-1:0] PC_INC         = 32'd4;

   // Opcode field of an instruction word: insn[6:0].
   localparam int unsigned OPCODE_MSB = 6;
   localparam int unsigned OPCODE_LSB = 0;
   localparam int unsigned OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

   // One buffered instruction together with the PC it was fetched from.
   typedef struct packed {
      logic [FETCH_AWIDTH-1:0] pc;
      logic [FETCH_DWIDTH-1:0] insn;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small registered instruction buffer for the fetch stage.
// Push/pop may happen in the same cycle; flush wins over push.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
   import fetch_unit_pkg::*;
#(
   parameter int unsigned DEPTH   = 2,
   parameter type         entry_t = fetch_entry_t,
   localparam int unsigned CW     = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push_i,
   input  entry_t        push_data_i,
   input  logic          pop_i,
   input  logic          flush_i,
   output entry_t        head_o,
   output logic [CW-1:0] count_o
);

   localparam int unsigned PW = $clog2(DEPTH);

   entry_t          entries_q [DEPTH];
   logic [PW-1:0]   wr_ptr_q;
   logic [PW-1:0]   rd_ptr_q;
   logic [CW-1:0]   count_q;

   // Storage, pointers and occupancy update.
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: the entries are cleared too, because the head entry drives
         // decode directly and must read as zero straight out of reset.
         for (int i = 0; i < DEPTH; i++) begin
            entries_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         // NOTE: non-blocking assignments here so every register samples the
         // pre-edge values; blocking would make pointer/count order-dependent.
         if (push_i) begin
            entries_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q            <= wr_ptr_q + 1'b1;
         end
         if (pop_i) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({push_i, pop_i})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign head_o  = entries_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order word requests,
// buffers returned instructions and presents them to decode.
// Redirects flush the buffer and discard responses still in flight.
// Optional build macro FETCH_MISALIGN_TRAP_EN: adds misalign_o; a redirect to
// a non-word-aligned target then halts fetch until an aligned redirect.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int unsigned          AWIDTH   = FETCH_AWIDTH,
   parameter int unsigned          DWIDTH   = FETCH_DWIDTH,
   parameter logic [AWIDTH-1:0]    BASEADDR = FETCH_BASEADDR,
   parameter int unsigned          DEPTH    = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                redirect_valid_i,
   input  logic [AWIDTH-1:0]   redirect_pc_i,
   output logic                imem_req_valid_o,
   input  logic                imem_req_ready_i,
   output logic [AWIDTH-1:0]   imem_req_addr_o,
   input  logic                imem_rsp_valid_i,
   input  logic [DWIDTH-1:0]   imem_rsp_data_i,
   output logic                dec_valid_o,
   input  logic                dec_ready_i,
   output logic [AWIDTH-1:0]   dec_pc_o,
   output logic [DWIDTH-1:0]   dec_insn_o,
`ifdef FETCH_MISALIGN_TRAP_EN
   output logic [OPCODE_W-1:0] dec_opcode_o,
   output logic                misalign_o
`else
   output logic [OPCODE_W-1:0] dec_opcode_o
`endif
);

   localparam int unsigned CW = $clog2(DEPTH + 1);

   // Same layout as fetch_entry_t, sized by this instance's widths.
   typedef struct packed {
      logic [AWIDTH-1:0] pc;
      logic [DWIDTH-1:0] insn;
   } entry_t;

   logic [AWIDTH-1:0] pc_q, pc_d;
   logic [AWIDTH-1:0] rsp_pc_q, rsp_pc_d;
   logic [CW-1:0]     outstanding_q, outstanding_d;
   logic [CW-1:0]     drop_cnt_q, drop_cnt_d;

   logic [CW-1:0]     fifo_count;
   entry_t            head;
   entry_t            push_entry;
   logic [CW:0]       credit_used;
   logic              fetch_halt;
   logic              req_fire;
   logic              rsp_push;
   logic              dec_pop;
   logic [AWIDTH-1:0] redir_pc;
   logic [AWIDTH-1:0] pc_inc;

   assign pc_inc   = AWIDTH'(PC_INC);
   // Masking keeps all target bits in use; the low two are always cleared.
   assign redir_pc = redirect_pc_i & ~AWIDTH'(3);

`ifdef FETCH_MISALIGN_TRAP_EN
   logic misalign_q, misalign_d;
   assign fetch_halt = misalign_q;
   assign misalign_o = misalign_q;
`else
   assign fetch_halt = 1'b0;
`endif

   // Credit: requests in flight plus buffered entries never exceed DEPTH,
   // so a returning response always finds room in the buffer.
   assign credit_used      = {1'b0, outstanding_q} + {1'b0, fifo_count};
   assign imem_req_valid_o = !reset && !redirect_valid_i && !fetch_halt &&
                             (credit_used < (CW+1)'(DEPTH));
   assign imem_req_addr_o  = pc_q;
   assign req_fire         = imem_req_valid_o && imem_req_ready_i;

   assign rsp_push   = imem_rsp_valid_i && (drop_cnt_q == '0) && !redirect_valid_i;
   assign push_entry = '{pc: rsp_pc_q, insn: imem_rsp_data_i};

   assign dec_valid_o  = (fifo_count != '0) && !redirect_valid_i;
   assign dec_pop      = dec_valid_o && dec_ready_i;
   assign dec_pc_o     = head.pc;
   assign dec_insn_o   = head.insn;
   assign dec_opcode_o = head.insn[OPCODE_MSB:OPCODE_LSB];

   fetch_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t)
   ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .push_i      (rsp_push),
      .push_data_i (push_entry),
      .pop_i       (dec_pop),
      .flush_i     (redirect_valid_i),
      .head_o      (head),
      .count_o     (fifo_count)
   );

   // Next-state for PCs and in-flight accounting; redirect has priority.
   always_comb begin
      // NOTE: every _d gets a default first so no path leaves it unassigned
      // (which would infer a latch).
      pc_d          = pc_q;
      rsp_pc_d      = rsp_pc_q;
      outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid_i);
      drop_cnt_d    = drop_cnt_q;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_d    = misalign_q;
`endif
      if (redirect_valid_i) begin
         pc_d       = redir_pc;
         rsp_pc_d   = redir_pc;
         // Every request still in flight becomes stale. Already-stale ones are
         // part of outstanding_q, so this equals drop_cnt plus the live ones,
         // less a response returning in this very cycle.
         drop_cnt_d = outstanding_q - CW'(imem_rsp_valid_i);
`ifdef FETCH_MISALIGN_TRAP_EN
         misalign_d = (redirect_pc_i[1:0] != 2'b00);
`endif
      end else begin
         if (req_fire) begin
            pc_d = pc_q + pc_inc;
         end
         if (rsp_push) begin
            rsp_pc_d = rsp_pc_q + pc_inc;
         end
         if (imem_rsp_valid_i && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - 1'b1;
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q          <= BASEADDR;
         rsp_pc_q      <= BASEADDR;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
         misalign_q    <= 1'b0;
`endif
      end else begin
         pc_q          <= pc_d;
         rsp_pc_q      <= rsp_pc_d;
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
`ifdef FETCH_MISALIGN_TRAP_EN
         misalign_q    <= misalign_d;
`endif
      end
   end

   a_credit : assert property (@(posedge clk) disable iff (reset)
      credit_used <= (CW+1)'(DEPTH));
   a_drop : assert property (@(posedge clk) disable iff (reset)
      drop_cnt_q <= outstanding_q);
   a_rsp_expected : assert property (@(posedge clk) disable iff (reset)
      imem_rsp_valid_i |-> (outstanding_q != '0));
   a_dec_hold : assert property (@(posedge clk) disable iff (reset)
      (dec_valid_o && !dec_ready_i) |=> ($stable(dec_pc_o) && $stable(dec_insn_o)));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
// Instruction memory model: accepted addresses queue up and are answered in
// order one per cycle (optionally held back); data = {addr[23:0], 0, addr[4:2], 4'h3}.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic        dec_valid;
   logic        dec_ready;
   logic [31:0] dec_pc;
   logic [31:0] dec_insn;
   logic [6:0]  dec_opcode;
`ifdef FETCH_MISALIGN_TRAP_EN
   logic        misalign;
`endif

   int          passed = 0;
   int          total  = 0;
   int          accepts;
   logic [31:0] last_acc;
   logic        rsp_en;
   logic [31:0] pend_q[$];
   logic [31:0] log_pc[$];
   logic [31:0] log_insn[$];

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk              (clk),
      .reset            (reset),
      .redirect_valid_i (redirect_valid),
      .redirect_pc_i    (redirect_pc),
      .imem_req_valid_o (req_valid),
      .imem_req_ready_i (req_ready),
      .imem_req_addr_o  (req_addr),
      .imem_rsp_valid_i (rsp_valid),
      .imem_rsp_data_i  (rsp_data),
      .dec_valid_o      (dec_valid),
      .dec_ready_i      (dec_ready),
      .dec_pc_o         (dec_pc),
      .dec_insn_o       (dec_insn),
`ifdef FETCH_MISALIGN_TRAP_EN
      .dec_opcode_o     (dec_opcode),
      .misalign_o       (misalign)
`else
      .dec_opcode_o     (dec_opcode)
`endif
   );

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return {a[23:0], 1'b0, a[4:2], 4'h3};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   // One clock cycle, entered and left at the falling edge.
   task automatic step();
      logic        fire;
      logic [31:0] faddr;
      if (rsp_en && pend_q.size() > 0) begin
         rsp_valid = 1'b1;
         rsp_data  = mem_data(pend_q.pop_front());
      end else begin
         rsp_valid = 1'b0;
         rsp_data  = '0;
      end
      #1;
      fire  = req_valid && req_ready;
      faddr = req_addr;
      if (dec_valid && dec_ready) begin
         log_pc.push_back(dec_pc);
         log_insn.push_back(dec_insn);
      end
      @(posedge clk);
      if (fire) begin
         pend_q.push_back(faddr);
         accepts++;
         last_acc = faddr;
      end
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset          = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      req_ready      = 1'b1;
      dec_ready      = 1'b1;
      rsp_valid      = 1'b0;
      rsp_data       = '0;
      rsp_en         = 1'b1;
      accepts        = 0;
      last_acc       = '0;

      // Reset state.
      @(negedge clk);
      step();
      step();
      check("rst_req_valid", 32'(req_valid), 32'h0);
      check("rst_req_addr",  req_addr,       32'h0100_0000);
      check("rst_dec_valid", 32'(dec_valid), 32'h0);
      check("rst_dec_pc",    dec_pc,         32'h0);
      check("rst_dec_insn",  dec_insn,       32'h0);
      check("rst_opcode",    32'(dec_opcode), 32'h0);

      // Streaming with immediate responses and decode always ready.
      reset = 1'b0;
      #1;
      check("s_req_valid0", 32'(req_valid), 32'h1);
      check("s_req_addr0",  req_addr,       32'h0100_0000);
      step();
      check("s_req_addr1",  req_addr,       32'h0100_0004);
      check("s_dec_valid1", 32'(dec_valid), 32'h0);
      step();
      check("s_dec_valid2", 32'(dec_valid), 32'h1);
      check("s_dec_pc2",    dec_pc,         32'h0100_0000);
      check("s_dec_insn2",  dec_insn,       32'h0000_0003);
      check("s_opcode2",    32'(dec_opcode), 32'h03);
      repeat (8) step();
      check("s_log_pc1",   log_pc[1],   32'h0100_0004);
      check("s_log_insn1", log_insn[1], 32'h0000_0413);
      check("s_log_pc3",   log_pc[3],   32'h0100_000C);
      check("s_log_insn3", log_insn[3], 32'h0000_0C33);

      // Drain, then reset mid-run; fetch restarts at the base address.
      req_ready = 1'b0;
      repeat (3) step();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      req_ready = 1'b1;
      dec_ready = 1'b0;
      accepts = 0;
      log_pc.delete();
      log_insn.delete();
      #1;
      check("rr_req_addr", req_addr, 32'h0100_0000);

      // Decode stalled for 10 cycles: credits cap requests at DEPTH.
      repeat (3) step();
      check("st_dec_pc_early", dec_pc, 32'h0100_0000);
      repeat (7) step();
      check("st_accepts",   32'(accepts),   32'd2);
      check("st_req_valid", 32'(req_valid), 32'h0);
      check("st_dec_valid", 32'(dec_valid), 32'h1);
      check("st_dec_pc",    dec_pc,         32'h0100_0000);
      check("st_dec_insn",  dec_insn,       32'h0000_0003);
      dec_ready = 1'b1;
      repeat (8) step();
      check("st_log_size", 32'(log_pc.size()), 32'd6);
      check("st_log_pc0",  log_pc[0], 32'h0100_0000);
      check("st_log_pc1",  log_pc[1], 32'h0100_0004);
      check("st_log_pc2",  log_pc[2], 32'h0100_0008);
      check("st_log_pc3",  log_pc[3], 32'h0100_000C);

      // Two requests outstanding, then redirect: both responses dropped.
      rsp_en = 1'b0;
      step();
      check("rd_credit_full", 32'(req_valid), 32'h0);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0100_0100;
      #1;
      check("rd_no_req", 32'(req_valid), 32'h0);
      step();
      redirect_valid = 1'b0;
      rsp_en = 1'b1;
      step();
      check("rd_drop1_dec_valid", 32'(dec_valid), 32'h0);
      step();
      check("rd_drop2_dec_valid", 32'(dec_valid), 32'h0);
      check("rd_first_req", last_acc, 32'h0100_0100);
      step();
      check("rd_dec_valid", 32'(dec_valid), 32'h1);
      check("rd_dec_pc",    dec_pc,         32'h0100_0100);
      check("rd_dec_insn",  dec_insn,       32'h0001_0003);

      // Redirect in the same cycle as a response.
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0100_0200;
      #1;
      check("rs_dec_valid_redirect", 32'(dec_valid), 32'h0);
      step();
      redirect_valid = 1'b0;
      #1;
      check("rs_req_valid", 32'(req_valid), 32'h1);
      check("rs_req_addr",  req_addr,       32'h0100_0200);
      step();
      step();
      check("rs_dec_pc",   dec_pc,   32'h0100_0200);
      check("rs_dec_insn", dec_insn, 32'h0002_0003);

      // Redirect to a misaligned target.
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0100_0102;
      step();
      redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      #1;
      check("ma_misalign_set", 32'(misalign),  32'h1);
      check("ma_req_blocked",  32'(req_valid), 32'h0);
      repeat (3) step();
      check("ma_req_still_blocked", 32'(req_valid), 32'h0);
      check("ma_dec_valid",         32'(dec_valid), 32'h0);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0100_0100;
      step();
      redirect_valid = 1'b0;
      #1;
      check("ma_misalign_clear", 32'(misalign), 32'h0);
`else
      #1;
`endif
      check("ma_req_valid", 32'(req_valid), 32'h1);
      check("ma_req_addr",  req_addr,       32'h0100_0100);
      step();
      step();
      check("ma_dec_pc",   dec_pc,   32'h0100_0100);
      check("ma_dec_insn", dec_insn, 32'h0001_0003);

      // PC wrap at the top of the address space.
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      step();
      redirect_valid = 1'b0;
      #1;
      check("wr_req_addr0", req_addr, 32'hFFFF_FFFC);
      step();
      check("wr_req_addr1", req_addr, 32'h0000_0000);
      step();
      check("wr_dec_pc0",   dec_pc,          32'hFFFF_FFFC);
      check("wr_dec_insn0", dec_insn,        32'hFFFF_FC73);
      check("wr_opcode0",   32'(dec_opcode), 32'h73);
      step();
      check("wr_dec_valid1", 32'(dec_valid), 32'h1);
      check("wr_dec_pc1",    dec_pc,         32'h0000_0000);
      check("wr_dec_insn1",  dec_insn,       32'h0000_0003);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
